// File: rtl/if_inst_collect.sv
// IF-stage fetch-response collector: pairs the IPF/IF entry with the I-cache word,
// stalls IPF/IF while the word is outstanding, holds it across ID stalls, drops squashed responses.
module if_inst_collect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ipf_if_valid,
  input  logic [31:0] ipf_if_exc,
  input  logic        ipf_if_inst_miss,
  input  logic        ipf_if_inst_valid,
  input  logic        inst_req_fire,
  input  logic        inst_rdata_valid,
  input  logic [31:0] inst_rdata,
  input  logic        id_stall,
  input  logic        if_flush,
  output logic        fetch_stall,
  output logic        if_valid,
  output logic [31:0] instruction,
  output logic [31:0] if_exc_type,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [1:0]  drop_cnt_reg, drop_cnt_next;
  logic [31:0] hold_reg, hold_next;
  logic        resp_err_reg, resp_err_next;

  logic exc_entry;
  logic fetch_ok;
  logic resp_use;
  logic cnt_overflow;
  logic cnt_underflow;
  logic capture;

  assign exc_entry = (|ipf_if_exc) | ipf_if_inst_miss | ~ipf_if_inst_valid;
  assign fetch_ok  = ipf_if_valid & ~exc_entry;
  assign resp_use  = inst_rdata_valid & (drop_cnt_reg == 2'd0);

  assign cnt_overflow  = (cnt_reg == 2'd3) & inst_req_fire & ~inst_rdata_valid;
  assign cnt_underflow = (cnt_reg == 2'd0) & inst_rdata_valid & ~inst_req_fire;

  // Word arrives while ID is stalled: park it until ID can take it.
  assign capture = ~if_flush & (state_reg != HOLD) & resp_use & fetch_ok & id_stall;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (if_flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, WAIT: begin
          if (resp_use && fetch_ok) begin
            state_next = id_stall ? HOLD : IDLE;
          end else if (state_reg == IDLE && fetch_ok) begin
            state_next = WAIT;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Response bookkeeping
  always_comb begin
    cnt_next      = cnt_reg + {1'b0, inst_req_fire} - {1'b0, inst_rdata_valid};
    drop_cnt_next = drop_cnt_reg;
    hold_next     = hold_reg;
    resp_err_next = resp_err_reg | cnt_overflow | cnt_underflow;
    if (if_flush) begin
      // Everything still in flight, including this cycle's request, belongs to the squashed path.
      drop_cnt_next = cnt_next;
      hold_next     = 32'd0;
    end else begin
      if (inst_rdata_valid && drop_cnt_reg != 2'd0) begin
        drop_cnt_next = drop_cnt_reg - 2'd1;
      end
      if (resp_use && !fetch_ok) begin
        resp_err_next = 1'b1;
      end
      if (capture) begin
        hold_next = inst_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg      <= 2'd0;
      drop_cnt_reg <= 2'd0;
      hold_reg     <= 32'd0;
      resp_err_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      drop_cnt_reg <= drop_cnt_next;
      hold_reg     <= hold_next;
      resp_err_reg <= resp_err_next;
    end
  end

  // Output logic
  always_comb begin
    if_valid    = ~if_flush & ipf_if_valid & (exc_entry | resp_use | (state_reg == HOLD));
    fetch_stall = fetch_ok & (state_reg != HOLD) & ~resp_use;
    if_exc_type = ipf_if_exc
                | {29'd0, ipf_if_inst_miss, 2'b00}
                | {28'd0, ~ipf_if_inst_miss & ~ipf_if_inst_valid, 3'b000};
    if (exc_entry) begin
      instruction = 32'd0;
    end else if (state_reg == HOLD) begin
      instruction = hold_reg;
    end else begin
      instruction = inst_rdata;
    end
  end

  assign resp_err = resp_err_reg;

endmodule

// File: tb/tb_if_inst_collect.sv
// Bench for if_inst_collect: directed scenarios plus randomized traffic,
// checked every cycle against a counter/queue-level model of the fetch protocol.
module tb_if_inst_collect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ipf_if_valid;
  logic [31:0] ipf_if_exc;
  logic        ipf_if_inst_miss;
  logic        ipf_if_inst_valid;
  logic        inst_req_fire;
  logic        inst_rdata_valid;
  logic [31:0] inst_rdata;
  logic        id_stall;
  logic        if_flush;
  logic        fetch_stall;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] if_exc_type;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_out;
  int          m_drop;
  bit          m_held;
  logic [31:0] m_word;
  bit          m_err;

  if_inst_collect dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ipf_if_valid     (ipf_if_valid),
    .ipf_if_exc       (ipf_if_exc),
    .ipf_if_inst_miss (ipf_if_inst_miss),
    .ipf_if_inst_valid(ipf_if_inst_valid),
    .inst_req_fire    (inst_req_fire),
    .inst_rdata_valid (inst_rdata_valid),
    .inst_rdata       (inst_rdata),
    .id_stall         (id_stall),
    .if_flush         (if_flush),
    .fetch_stall      (fetch_stall),
    .if_valid         (if_valid),
    .instruction      (instruction),
    .if_exc_type      (if_exc_type),
    .resp_err         (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_exc();
    return (ipf_if_exc != 0) || ipf_if_inst_miss || !ipf_if_inst_valid;
  endfunction

  // Compare every output with the model's view of the current cycle.
  task automatic model_check();
    bit          use_w;
    bit          e;
    logic [31:0] exp_instr;
    logic [31:0] exp_exc;
    e      = is_exc();
    use_w  = inst_rdata_valid && (m_drop == 0);
    exp_instr = e ? 32'd0 : (m_held ? m_word : inst_rdata);
    exp_exc   = ipf_if_exc;
    if (ipf_if_inst_miss) exp_exc = exp_exc | 32'h4;
    else if (!ipf_if_inst_valid) exp_exc = exp_exc | 32'h8;
    chk("if_valid", {31'd0, if_valid}, {31'd0, !if_flush && ipf_if_valid && (e || use_w || m_held)});
    chk("instruction", instruction, exp_instr);
    chk("if_exc_type", if_exc_type, exp_exc);
    chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, ipf_if_valid && !e && !m_held && !use_w});
    chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
  endtask

  // Advance the model across the clock edge, then wait for it.
  task automatic tick();
    bit use_w;
    bit ok;
    int nxt;
    use_w = inst_rdata_valid && (m_drop == 0);
    ok    = ipf_if_valid && !is_exc();
    nxt   = m_out + int'(inst_req_fire) - int'(inst_rdata_valid);
    if (nxt < 0 || nxt > 3) m_err = 1;
    if (if_flush) begin
      m_drop = nxt;
      m_held = 0;
      m_word = 0;
    end else begin
      if (inst_rdata_valid && m_drop > 0) m_drop--;
      if (use_w && !ok) m_err = 1;
      if (m_held) begin
        if (!id_stall) m_held = 0;
      end else if (use_w && ok && id_stall) begin
        m_held = 1;
        m_word = inst_rdata;
      end
    end
    m_out = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic rv, input logic [31:0] rd,
                       input logic st, input logic fl);
    inst_req_fire    = f;
    inst_rdata_valid = rv;
    inst_rdata       = rd;
    id_stall         = st;
    if_flush         = fl;
    #2;
    model_check();
  endtask

  task automatic set_entry(input logic v, input logic [31:0] e, input logic miss, input logic iv);
    ipf_if_valid      = v;
    ipf_if_exc        = e;
    ipf_if_inst_miss  = miss;
    ipf_if_inst_valid = iv;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_entry(1'b0, 32'd0, 1'b0, 1'b1);
    inst_req_fire = 0; inst_rdata_valid = 0; inst_rdata = 0; id_stall = 0; if_flush = 0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_out  = 0; m_drop = 0; m_held = 0; m_word = 0; m_err = 0;
  endtask

  initial begin
    do_reset();
    drive(0, 0, 32'd0, 0, 0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_exc", if_exc_type, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    tick();

    // Hit: response the cycle after the request
    set_entry(1, 0, 0, 1);
    drive(1, 0, 32'd0, 0, 0);
    chk("hit_t0_stall", {31'd0, fetch_stall}, 32'd1);
    tick();
    drive(0, 1, 32'h24020005, 0, 0);
    chk("hit_t1_valid", {31'd0, if_valid}, 32'd1);
    chk("hit_t1_instr", instruction, 32'h24020005);
    chk("hit_t1_stall", {31'd0, fetch_stall}, 32'd0);
    tick();

    // Miss with response four cycles later
    drive(1, 0, 32'd0, 0, 0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 32'hDEAD0000 + i, 0, 0);
      chk("miss_stall", {31'd0, fetch_stall}, 32'd1);
      chk("miss_nvalid", {31'd0, if_valid}, 32'd0);
      tick();
    end
    drive(0, 1, 32'h11112222, 0, 0);
    chk("miss_t4_valid", {31'd0, if_valid}, 32'd1);
    tick();

    // ID stall holds the word
    drive(1, 0, 32'd0, 0, 0);
    tick();
    drive(0, 1, 32'h8FA40010, 1, 0);
    tick();
    for (int i = 2; i <= 3; i++) begin
      drive(0, 0, 32'h0, 1, 0);
      chk("hold_instr", instruction, 32'h8FA40010);
      chk("hold_stall", {31'd0, fetch_stall}, 32'd0);
      tick();
    end
    drive(0, 0, 32'h0, 0, 0);
    chk("hold_rel_instr", instruction, 32'h8FA40010);
    chk("hold_rel_valid", {31'd0, if_valid}, 32'd1);
    tick();
    set_entry(0, 0, 0, 1);
    drive(0, 0, 32'h0, 0, 0);
    chk("hold_after_valid", {31'd0, if_valid}, 32'd0);
    tick();

    // Flush with two outstanding plus a request in the flush cycle
    set_entry(1, 0, 0, 1);
    drive(1, 0, 32'h0, 0, 0); tick();
    drive(1, 0, 32'h0, 0, 0); tick();
    drive(1, 0, 32'h0, 0, 1);
    chk("flush_valid", {31'd0, if_valid}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'hBAD00000 + i, 0, 0);
      chk("drop_valid", {31'd0, if_valid}, 32'd0);
      tick();
      chk("drop_err", {31'd0, resp_err}, 32'd0);
    end
    drive(1, 0, 32'h0, 0, 0); tick();
    drive(0, 1, 32'h0C0FFEE0, 0, 0);
    chk("post_drop_valid", {31'd0, if_valid}, 32'd1);
    chk("post_drop_instr", instruction, 32'h0C0FFEE0);
    tick();

    // ITLB miss / invalid entries deliver immediately
    set_entry(1, 0, 1, 1);
    drive(0, 0, 32'h12345678, 0, 0);
    chk("tlbm_valid", {31'd0, if_valid}, 32'd1);
    chk("tlbm_instr", instruction, 32'd0);
    chk("tlbm_exc", if_exc_type, 32'h4);
    chk("tlbm_stall", {31'd0, fetch_stall}, 32'd0);
    tick();
    set_entry(1, 0, 0, 0);
    drive(0, 0, 32'h12345678, 0, 0);
    chk("tlbinv_exc", if_exc_type, 32'h8);
    tick();

    // Randomized traffic respecting the cache protocol
    for (int c = 0; c < 1500; c++) begin
      logic v, f, rv, st, fl;
      int   r;
      r = $urandom_range(0, 15);
      v = ($urandom_range(0, 7) != 0);
      set_entry(v, (r == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'd0, r == 1, r != 2);
      f  = (m_out < 3) && ($urandom_range(0, 2) == 0);
      rv = !m_held && (m_out > 0) && ($urandom_range(0, 2) == 0);
      if (m_drop == 0 && !(v && !is_exc())) rv = 0;
      st = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 31) == 0);
      drive(f, rv, $urandom, st, fl);
      tick();
    end

    // Drain, then a spurious response sets the sticky error
    set_entry(0, 0, 0, 1);
    drive(0, 0, 32'h0, 0, 1); tick();
    while (m_out > 0) begin
      drive(0, 1, 32'h0, 0, 0); tick();
    end
    drive(0, 0, 32'h0, 0, 0);
    chk("pre_spur_err", {31'd0, resp_err}, 32'd0);
    tick();
    drive(0, 1, 32'h55555555, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0, 0);
      chk("spur_err", {31'd0, resp_err}, 32'd1);
      tick();
    end
    do_reset();
    drive(0, 0, 32'h0, 0, 0);
    chk("err_cleared", {31'd0, resp_err}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_inst_collect.md
# if_inst_collect

IF-stage fetch-response collector, sitting downstream of the IPF/IF pipeline registers. It pairs the entry latched in IPF/IF (PC+4, delay-slot flag, fetch exception, TLB miss/valid) with the instruction word returned by the I-cache. It raises the IPF/IF stall while the word is outstanding and holds the word if ID is stalled. On a flush it discards in-flight responses belonging to the squashed path.

## Interface
- No parameters.
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset synchronous active-low
- ipf_if_valid  in  1  IPF/IF entry holds a real fetch
- ipf_if_exc  in  32  registered fetch exception type
- ipf_if_inst_miss  in  1  registered ITLB miss
- ipf_if_inst_valid  in  1  registered ITLB valid
- inst_req_fire  in  1  I-cache accepted a fetch request this cycle
- inst_rdata_valid  in  1  one-cycle I-cache response pulse
- inst_rdata  in  32  response word
- id_stall  in  1  ID cannot accept this cycle
- if_flush  in  1  squash IF/IPF
- fetch_stall  out  1  OR'd into IPF_IF_Stall at top level
- if_valid  out  1  instruction presented to IF/ID this cycle
- instruction  out  32  instruction to IF/ID
- if_exc_type  out  32  exception type to IF/ID
- resp_err  out  1  sticky protocol-error flag

## Operation
- exc_entry = ipf_if_exc != 0 or ipf_if_inst_miss or !ipf_if_inst_valid. No cache request exists for such an entry.
- if_exc_type = ipf_if_exc | (inst_miss << 2) | ((!inst_miss & !inst_valid) << 3).
- outstanding cnt (2-bit): next = cnt + inst_req_fire − inst_rdata_valid. Reaching 4 or going below 0 sets resp_err.
- drop_cnt (2-bit): resp_use = inst_rdata_valid & drop_cnt==0. A response with drop_cnt>0 is discarded and decrements drop_cnt.
- State machine with states IDLE, WAIT, HOLD. hold_reg is 32 bits.
  - IDLE, valid non-exc entry, no resp_use: go to WAIT.
  - IDLE or WAIT, resp_use, id_stall=1: hold_reg ← inst_rdata, go to HOLD.
  - IDLE or WAIT, resp_use, id_stall=0: delivered, go to IDLE.
  - HOLD, id_stall=0: delivered, go to IDLE.
  - HOLD, id_stall=1: stay in HOLD.
- resp_use with ipf_if_valid=0 or exc_entry: word ignored, resp_err←1.
- if_valid = ipf_if_valid & (exc_entry | resp_use | state==HOLD).
- instruction = 0 if exc_entry; hold_reg in HOLD; otherwise inst_rdata.
- fetch_stall = ipf_if_valid & !exc_entry & state!=HOLD & !resp_use.
- if_flush has priority over every transition:
  - state←IDLE, hold_reg←0.
  - drop_cnt ← cnt + inst_req_fire − inst_rdata_valid, so every pending response is dropped, including one requested in the flush cycle.
  - A response in the flush cycle is never delivered.
  - if_valid is forced to 0 in the flush cycle.

## Timing
- Reset (rst_n=0 at posedge): state IDLE, cnt 0, drop_cnt 0, hold_reg 0, resp_err 0. Outputs then: if_valid 0 and fetch_stall 0 while ipf_if_valid=0. instruction 0, if_exc_type 0 with zero inputs.
- Reset mid-WAIT or mid-HOLD: the held word is lost. Later responses are counted as errors unless cnt=0; the bench keeps the cache idle around reset.
- Latency is 0 cycles from response to if_valid, combinational. A held word appears the cycle after the response and persists until the first cycle with id_stall=0.
- Exception entries deliver in the same cycle with no stall.
- fetch_stall is combinational. It deasserts in the cycle resp_use rises.
- Simultaneous inst_req_fire and inst_rdata_valid leave cnt unchanged.
- A flush while drop_cnt>0 overwrites drop_cnt with the new outstanding total.
- resp_err is cleared only by reset.

## Test plan
- Hit: req_fire at t0, rdata_valid with 0x24020005 at t1, id_stall=0 → t0 fetch_stall=1. t1 if_valid=1, instruction=0x24020005, fetch_stall=0. t2 state IDLE, cnt=0.
- Miss latency 4: response at t4 → fetch_stall=1 for t1..t3, if_valid=1 only at t4.
- ID stall: response 0x8FA40010 with id_stall=1 for t1..t3 → HOLD. instruction=0x8FA40010 and fetch_stall=0 for t2..t4. Release at t4, IDLE at t5.
- Flush with 2 outstanding plus req_fire in the flush cycle → drop_cnt=3. The next 3 responses are ignored (if_valid=0, resp_err=0). The 4th response, after a fresh request, is delivered.
- ITLB miss entry (inst_miss=1, exc=0) → same cycle if_valid=1, instruction=0, if_exc_type=0x4, fetch_stall=0. With inst_valid=0 and miss=0 → if_exc_type=0x8.
- Spurious rdata_valid with cnt=0, drop_cnt=0 → resp_err=1 next cycle, stays 1 until rst_n=0.
